// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous SRAM between an instruction-fetch port and a
// load/store data port, and steers read data back to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [2:0]          starve_cnt_o
);

  logic [2:0]        starve_cnt_reg, starve_cnt_next;
  logic              fetch_prio;
  logic              rd_grant;
  logic [RD_LAT-1:0] pipe_valid_reg, pipe_valid_next;
  logic [RD_LAT-1:0] pipe_owner_reg, pipe_owner_next;
  logic              out_valid;
  logic              out_owner;

  // Data wins by default; fetch takes over once it has waited STARVE_MAX cycles.
  assign fetch_prio = int'(starve_cnt_reg) >= STARVE_MAX;
  assign i_gnt      = i_req & (~d_req | fetch_prio);
  assign d_gnt      = d_req & ~i_gnt;
  assign rd_grant   = i_gnt | (d_gnt & ~d_we);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en   = 1'b1;
      mem_addr = d_addr;
      if (d_we) begin
        mem_we    = d_wstrb;
        mem_wdata = d_wdata;
      end
    end else if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end
  end

  always_comb begin
    starve_cnt_next = 3'd0;
    if (i_req && !i_gnt)
      starve_cnt_next = (starve_cnt_reg == 3'd7) ? 3'd7 : starve_cnt_reg + 3'd1;
  end

  // Owner pipe: stage 0 takes the new grant, stage RD_LAT-1 lines up with mem_rdata.
  // A flush kills i-owned entries as they shift, but never the entry pushed this cycle.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_next[gi] = rd_grant;
        assign pipe_owner_next[gi] = d_gnt;
      end else begin : g_body
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1] & ~(i_flush & ~pipe_owner_reg[gi-1]);
        assign pipe_owner_next[gi] = pipe_owner_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= 3'd0;
      pipe_valid_reg <= '0;
      pipe_owner_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      pipe_valid_reg <= pipe_valid_next;
      pipe_owner_reg <= pipe_owner_next;
    end
  end

  assign out_valid    = pipe_valid_reg[RD_LAT-1];
  assign out_owner    = pipe_owner_reg[RD_LAT-1];
  assign i_rvalid     = out_valid & ~out_owner & ~i_flush;
  assign d_rvalid     = out_valid & out_owner;
  assign i_rdata      = i_rvalid ? mem_rdata : '0;
  assign d_rdata      = d_rvalid ? mem_rdata : '0;
  assign starve_cnt_o = starve_cnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level
// reference model (grant rule, shadow memory, queue of expected responses).
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_flush, i_gnt, i_rvalid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [3:0]        d_wstrb;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [2:0]        starve_cnt_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_cnt_o(starve_cnt_o)
  );

  // Environment SRAM: byte-write, RD_LAT-cycle read latency, word k preloaded with k.
  logic              preload;
  logic [DATA_W-1:0] sram    [256];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) sram[k] <= DATA_W'(k);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (mem_en && mem_we == 4'd0) ? sram[mem_addr[9:2]] : 32'h0BAD0BAD;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    int          due;
    bit          owner;   // 0 = fetch, 1 = data
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] shadow [256];
  int          starve;
  int          cyc;
  int          n_checks;
  int          n_pass;
  bit          last_ig, last_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge, then advance.
  task automatic cycle();
    bit          exp_ig, exp_dg, exp_irv, exp_drv;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr, exp_wd, exp_ird, exp_drd;
    resp_t       keep[$];
    resp_t       r;
    @(negedge clk);
    if (rst) begin
      q.delete();
      starve = 0;
    end
    if (i_flush) begin
      foreach (q[k]) if (q[k].owner) keep.push_back(q[k]);
      q = keep;
    end
    exp_ig   = i_req && (!d_req || starve >= STARVE_MAX);
    exp_dg   = d_req && !exp_ig;
    exp_addr = exp_dg ? d_addr : (exp_ig ? i_addr : 32'd0);
    exp_we   = (exp_dg && d_we) ? d_wstrb : 4'd0;
    exp_wd   = (exp_dg && d_we) ? d_wdata : 32'd0;
    exp_irv = 1'b0; exp_drv = 1'b0; exp_ird = 32'd0; exp_drd = 32'd0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.owner) begin exp_drv = 1'b1; exp_drd = r.data; end
      else         begin exp_irv = 1'b1; exp_ird = r.data; end
    end
    chk("i_gnt",      {31'd0, i_gnt},      {31'd0, exp_ig});
    chk("d_gnt",      {31'd0, d_gnt},      {31'd0, exp_dg});
    chk("mem_en",     {31'd0, mem_en},     {31'd0, exp_ig | exp_dg});
    chk("mem_we",     {28'd0, mem_we},     {28'd0, exp_we});
    chk("mem_addr",   mem_addr,            exp_addr);
    chk("mem_wdata",  mem_wdata,           exp_wd);
    chk("i_rvalid",   {31'd0, i_rvalid},   {31'd0, exp_irv});
    chk("i_rdata",    i_rdata,             exp_ird);
    chk("d_rvalid",   {31'd0, d_rvalid},   {31'd0, exp_drv});
    chk("d_rdata",    d_rdata,             exp_drd);
    chk("starve_cnt", {29'd0, starve_cnt_o}, 32'(starve));
    if (exp_dg && d_we) begin
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      $display("cyc %0d: store addr=%h data=%h strb=%h", cyc, d_addr, d_wdata, d_wstrb);
    end else if (exp_dg) begin
      q.push_back('{due: cyc + RD_LAT, owner: 1'b1, data: shadow[d_addr[9:2]]});
      $display("cyc %0d: load  addr=%h", cyc, d_addr);
    end else if (exp_ig) begin
      q.push_back('{due: cyc + RD_LAT, owner: 1'b0, data: shadow[i_addr[9:2]]});
      $display("cyc %0d: fetch addr=%h flush=%0d", cyc, i_addr, i_flush);
    end
    starve  = (i_req && !exp_ig) ? ((starve < 7) ? starve + 1 : 7) : 0;
    last_ig = exp_ig;
    last_dg = exp_dg;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; d_we = 0; i_flush = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
  endtask

  bit ip, dp;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; starve = 0;
    rst = 1; preload = 1;
    idle();
    for (int k = 0; k < 256; k++) shadow[k] = 32'(k);
    cycle(); cycle();
    rst = 0; preload = 0;

    // Back-to-back fetches of words 0, 1, 2
    for (int k = 0; k < 3; k++) begin
      i_req = 1; i_addr = 32'(4 * k);
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Contention: fetch held at 0x20 while a load stream competes
    i_req = 1; i_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      d_req = 1; d_we = 0; d_addr = 32'h40 + 32'(4 * k);
      if (k == 5) i_addr = 32'h24;
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Store / load, full then partial strobe
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; cycle();
    d_we = 0; d_wdata = 0; d_wstrb = 0; cycle();
    d_we = 1; d_wdata = 32'h0000AAAA; d_wstrb = 4'h3; cycle();
    d_we = 0; d_wdata = 0; d_wstrb = 0; cycle();
    idle();
    repeat (3) cycle();

    // Flush: load in flight, fetch at t squashed, fetch at t+1 with flush survives
    d_req = 1; d_addr = 32'h48; i_req = 1; i_addr = 32'h10; cycle();
    d_req = 0; cycle();
    i_addr = 32'h14; i_flush = 1; cycle();
    idle();
    repeat (4) cycle();

    // Reset between a load grant and its response
    d_req = 1; d_addr = 32'h44; cycle();
    idle(); rst = 1; cycle();
    rst = 0;
    repeat (4) cycle();

    // Idle
    repeat (10) cycle();

    // Randomized traffic, requests held until granted
    ip = 0; dp = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; i_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!dp && $urandom_range(0, 4) < 2) begin
        dp = 1; d_we = $urandom_range(0, 1) == 1;
        d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata = $urandom; d_wstrb = 4'($urandom_range(1, 15));
      end
      i_req = ip; d_req = dp;
      i_flush = ($urandom_range(0, 9) == 0);
      cycle();
      if (last_ig) ip = 0;
      if (last_dg) dp = 0;
    end
    idle();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
